// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 4-digit common-anode 7-segment scanner with per-digit blanking
module seg7_scan #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [1:0]  digit_sel,
  output logic        frame_start
);
  localparam int MX = DIGIT_TICKS > BLANK_TICKS ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [15:0] sh_val;
  logic [3:0] sh_dp, sh_en, anode_nx;
  logic [6:0] seg_nx;
  logic [3:0] nib;
  logic [1:0] sel_nx;
  logic dp_nx, fs_nx, latch, lit, blank_done, show_done;
  always_comb begin
    nib = sh_val[{digit_sel, 2'b00} +: 4];
    lit = sh_en[digit_sel];
    blank_done = state == BLANK && cnt == CW'(BLANK_TICKS - 1);
    show_done = state == SHOW && cnt == CW'(DIGIT_TICKS - 1);
    state_nx = state;
    cnt_nx = cnt + 1'b1;
    sel_nx = digit_sel;
    latch = 1'b0;
    fs_nx = 1'b0;
    anode_nx = 4'hF;
    seg_nx = 7'h7F;
    dp_nx = 1'b1;
    if (!en) begin
      state_nx = IDLE;
      cnt_nx = '0;
      sel_nx = '0;
    end else if (state == IDLE) begin
      state_nx = BLANK;
      cnt_nx = '0;
      sel_nx = '0;
      latch = 1'b1;
      fs_nx = 1'b1;
    end else if (show_done) begin
      state_nx = BLANK;
      cnt_nx = '0;
      sel_nx = digit_sel + 2'd1;
      latch = digit_sel == 2'd3;
      fs_nx = latch;
    end else if (blank_done || state == SHOW) begin
      // outputs are registered, so the digit drive is loaded on the edge that enters SHOW
      state_nx = SHOW;
      cnt_nx = blank_done ? '0 : cnt + 1'b1;
      anode_nx = lit ? ~(4'b0001 << digit_sel) : 4'hF;
      seg_nx = lit ? HEX[nib] : 7'h7F;
      dp_nx = lit ? ~sh_dp[digit_sel] : 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      digit_sel <= '0;
      frame_start <= 1'b0;
      anode <= 4'hF;
      seg <= 7'h7F;
      dp_n <= 1'b1;
      sh_val <= '0;
      sh_dp <= '0;
      sh_en <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      digit_sel <= sel_nx;
      frame_start <= fs_nx;
      anode <= anode_nx;
      seg <= seg_nx;
      dp_n <= dp_nx;
      if (latch) begin
        sh_val <= value;
        sh_dp <= dp_in;
        sh_en <= digit_en;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed checks of the scan sequence with DIGIT_TICKS=4, BLANK_TICKS=2
module tb_seg7_scan;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic [15:0] value = 16'h4321;
  logic [3:0] dp_in = 4'h0, digit_en = 4'hF;
  logic [3:0] anode;
  logic [6:0] seg;
  logic dp_n, frame_start;
  logic [1:0] digit_sel;
  int checks = 0, failures = 0;
  logic [3:0] prev_anode = 4'hF;
  logic [6:0] prev_seg = 7'h7F;

  seg7_scan #(.DIGIT_TICKS(4), .BLANK_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .anode(anode), .seg(seg), .dp_n(dp_n), .digit_sel(digit_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexseg(logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // k counts cycles since the frame_start cycle: 2 blank + 4 lit per digit slot
  function automatic logic [11:0] expo(int k, logic [15:0] v, logic [3:0] d, logic [3:0] e);
    int p, dg;
    logic [3:0] nb;
    p = k % 6;
    dg = (k / 6) % 4;
    if (p < 2 || !e[dg]) return {4'hF, 7'h7F, 1'b1};
    nb = v[dg*4 +: 4];
    return {~(4'b0001 << dg), hexseg(nb), ~d[dg]};
  endfunction

  always @(negedge clk) begin
    if (anode != 4'hF) begin
      checks++;
      if ($countones(~anode) > 1) begin
        failures++;
        $display("FAIL one_cold anode=%b", anode);
      end
      if (prev_anode != 4'hF && seg != prev_seg) begin
        failures++;
        $display("FAIL seg_stable_while_lit seg=%h prev=%h anode=%b", seg, prev_seg, anode);
      end
    end
    prev_anode = anode;
    prev_seg = seg;
  end

  task automatic restart();
    rst_n = 1'b1;
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    value = 16'h4321;
    dp_in = 4'h0;
    digit_en = 4'hF;
    repeat (2) @(negedge clk);
    checks++;
    if ({anode, seg, dp_n, digit_sel, frame_start} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got=%b_%h_%b_%0d_%b", anode, seg, dp_n, digit_sel, frame_start);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      checks++;
      if ({anode, seg, dp_n} !== expo(k, 16'h4321, 4'h0, 4'hF) || digit_sel !== 2'((k / 6) % 4)
          || frame_start !== (k == 0)) begin
        failures++;
        $display("FAIL reset_release k=%0d got=%h sel=%0d fs=%b exp=%h", k, {anode, seg, dp_n},
                 digit_sel, frame_start, expo(k, 16'h4321, 4'h0, 4'hF));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_dp_seq();
    value = 16'hFEDC;
    dp_in = 4'b0100;
    digit_en = 4'hF;
    restart();
    for (int k = 0; k < 48; k++) begin
      checks++;
      if ({anode, seg, dp_n} !== expo(k, 16'hFEDC, 4'b0100, 4'hF) || digit_sel !== 2'((k / 6) % 4)
          || frame_start !== (k % 24 == 0)) begin
        failures++;
        $display("FAIL dp_seq k=%0d got=%h sel=%0d fs=%b exp=%h", k, {anode, seg, dp_n},
                 digit_sel, frame_start, expo(k, 16'hFEDC, 4'b0100, 4'hF));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_midframe();
    value = 16'h1111;
    dp_in = 4'h0;
    digit_en = 4'hF;
    restart();
    for (int k = 0; k < 48; k++) begin
      checks++;
      if ({anode, seg, dp_n} !== expo(k, k < 24 ? 16'h1111 : 16'h2222, 4'h0, 4'hF)) begin
        failures++;
        $display("FAIL midframe k=%0d got=%h exp=%h", k, {anode, seg, dp_n},
                 expo(k, k < 24 ? 16'h1111 : 16'h2222, 4'h0, 4'hF));
      end
      if (k == 9) value = 16'h2222;
      @(negedge clk);
    end
  endtask

  task automatic test_digit_en();
    value = 16'h4321;
    dp_in = 4'hF;
    digit_en = 4'b0101;
    restart();
    for (int k = 0; k < 25; k++) begin
      checks++;
      if ({anode, seg, dp_n} !== expo(k, 16'h4321, 4'hF, 4'b0101) || frame_start !== (k % 24 == 0)) begin
        failures++;
        $display("FAIL digit_en k=%0d got=%h fs=%b exp=%h", k, {anode, seg, dp_n}, frame_start,
                 expo(k, 16'h4321, 4'hF, 4'b0101));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_en_drop();
    value = 16'h4321;
    dp_in = 4'h0;
    digit_en = 4'hF;
    restart();
    repeat (15) @(negedge clk);
    checks++;
    if (anode !== 4'b1011 || seg !== 7'h30) begin
      failures++;
      $display("FAIL en_drop_pre got=%b_%h exp=1011_30", anode, seg);
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({anode, seg, dp_n, digit_sel, frame_start} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
        failures++;
        $display("FAIL en_drop_dark i=%0d got=%b_%h_%b_%0d_%b", i, anode, seg, dp_n, digit_sel, frame_start);
      end
    end
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({anode, seg, dp_n} !== expo(k, 16'h4321, 4'h0, 4'hF) || digit_sel !== 2'((k / 6) % 4)
          || frame_start !== (k == 0)) begin
        failures++;
        $display("FAIL en_restart k=%0d got=%h sel=%0d fs=%b exp=%h", k, {anode, seg, dp_n},
                 digit_sel, frame_start, expo(k, 16'h4321, 4'h0, 4'hF));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_mid();
    value = 16'h4321;
    restart();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({anode, seg, dp_n, digit_sel, frame_start} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid got=%b_%h_%b_%0d_%b", anode, seg, dp_n, digit_sel, frame_start);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || anode !== 4'hF) begin
      failures++;
      $display("FAIL rst_mid_restart fs=%b anode=%b exp fs=1 anode=1111", frame_start, anode);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (anode !== 4'b1110 || seg !== 7'h79) begin
      failures++;
      $display("FAIL rst_mid_digit0 got=%b_%h exp=1110_79", anode, seg);
    end
  endtask

  initial begin
    test_reset();
    test_dp_seq();
    test_midframe();
    test_digit_en();
    test_en_drop();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
